seq_mul_param: RTL and testbench
================================

Name: seq_mul_param

Overview:
- Parametrised multi-cycle multiplier for the ALU multiply slot of the CPU datapath.
- Replaces the fixed 8-bit combinational signed multiplier with a W-bit radix-2 Booth engine.
- Supports runtime signed/unsigned mode and a START/BUSY/DONE handshake.
- Provides the full 2W-bit product plus a W-bit low half for the register file.

Parameters:
- WIDTH, 8: operand width W in bits, legal range 4..32. Product width is 2W.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only in IDLE or DONE state.
- SIGNED_MODE  input  1  1 = two's-complement operands, 0 = unsigned; sampled with START.
- DATA1  input  W  multiplicand; sampled with START.
- DATA2  input  W  multiplier; sampled with START.
- BUSY  output  1  high while iterating.
- DONE  output  1  one-cycle pulse when RESULT updates.
- RESULT  output  2W  registered full product.
- MUL_OUT  output  W  always equals RESULT[W-1:0].

Behaviour:
- Reset: one clock and one reset. On the CLK edge with RESET=1:
  - state goes to IDLE;
  - BUSY=0, DONE=0, RESULT=0, MUL_OUT=0;
  - iteration counter and internal accumulator are cleared.
  - RESET overrides START.
  - RESET during RUN aborts the operation: no DONE pulse, RESULT becomes 0.
- State machine IDLE / RUN / FIN:
  - IDLE, START=1: latch operands extended to W+1 bits (sign-extend if SIGNED_MODE=1, else zero-extend). Clear accumulator, counter=0, go to RUN, BUSY=1.
  - RUN: one Booth step per edge. Examine {Q[0], Q_-1}:
    - 10: A -= M
    - 01: A += M
    - 00/11: no-op
    - then arithmetic right shift of {A,Q,Q_-1} by one. A and M are W+2 bits wide to absorb the unsigned-extension overflow.
    - counter increments each step.
    - After step W+1, go to FIN. RESULT is loaded from the low 2W bits of {A,Q}. BUSY=0, DONE=1.
  - FIN: DONE=1 for exactly this cycle.
    - START=1 here is accepted exactly as in IDLE: back-to-back operation, next state RUN, DONE returns to 0.
    - Otherwise go to IDLE, DONE=0.
- Latency: START sampled at edge k, BUSY high after edge k, RESULT valid and DONE high after edge k+W+1. Fixed W+1 cycles regardless of mode or operand values.
- START in RUN is ignored, and no queueing occurs. DATA1, DATA2 and SIGNED_MODE may change freely after the sampling edge.
- RESULT holds its previous value throughout RUN. It changes only on the final step edge or on RESET.
- Arithmetic boundaries (W=8 examples):
  - signed most-negative x most-negative = +2^(2W-2), e.g. 16'h4000;
  - unsigned max x max = 16'hFE01;
  - any operand 0 gives 0;
  - all results are exact, never truncated, in 2W bits.

Optional Feature:
- Macro: SEQ_MUL_OVERFLOW_FLAG_EN.
- Defined:
  - adds output OVERFLOW (1 bit), registered, reset 0, updated on the same edge as RESULT;
  - OVERFLOW=1 when the product does not fit in W bits;
  - signed mode: RESULT[2W-1:W-1] not all equal;
  - unsigned mode: RESULT[2W-1:W] nonzero;
  - OVERFLOW holds until the next RESULT update or RESET.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan (WIDTH=8):
- Reset, then signed -3 x 5 (DATA1=8'hFD, DATA2=8'h05, SIGNED_MODE=1), START at edge k.
  - BUSY=1 during edges k+1..k+8.
  - DONE=1 after edge k+9 only.
  - RESULT=16'hFFF1, MUL_OUT=8'hF1, OVERFLOW=0.
- Same operands, SIGNED_MODE=0 (253 x 5) -> RESULT=16'h04F1, OVERFLOW=1.
- Signed 8'h80 x 8'h80 -> RESULT=16'h4000, OVERFLOW=1.
- Unsigned 8'hFF x 8'hFF -> 16'hFE01. Then signed 8'hFF x 8'hFF started in the FIN cycle:
  - back-to-back operation, no idle gap;
  - RESULT=16'h0001 exactly 9 cycles later.
- START pulsed mid-RUN with different operands -> ignored; original product delivered with a single DONE pulse.
- RESET asserted at the 4th RUN cycle with START held high:
  - IDLE after that edge, RESULT=0, no DONE;
  - after RESET releases, the held START launches a fresh operation with correct result.

Source files
------------

// File: rtl/seq_mul_param_if.sv
// Handshake and data bundle for the sequential Booth multiplier.
// SEQ_MUL_OVERFLOW_FLAG_EN adds the overflow flag to the bundle.
interface seq_mul_param_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     data1;
  logic [WIDTH-1:0]     data2;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     mul_out;
`ifdef SEQ_MUL_OVERFLOW_FLAG_EN
  logic                 overflow;

  modport master (
    output start, signed_mode, data1, data2,
    input  busy, done, result, mul_out, overflow
  );
  modport slave (
    input  start, signed_mode, data1, data2,
    output busy, done, result, mul_out, overflow
  );
`else
  modport master (
    output start, signed_mode, data1, data2,
    input  busy, done, result, mul_out
  );
  modport slave (
    input  start, signed_mode, data1, data2,
    output busy, done, result, mul_out
  );
`endif
endinterface

// File: rtl/seq_mul_param.sv
// W-bit radix-2 Booth multiplier, signed/unsigned at runtime, fixed W+1 step latency.
// Optional OVERFLOW output enabled by defining SEQ_MUL_OVERFLOW_FLAG_EN.
module seq_mul_param #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  seq_mul_param_if.slave    bus
);
  localparam int AW = WIDTH + 2;
  localparam int QW = WIDTH + 1;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            accept_s;
  logic            last_s;
  logic            busy_r;
  logic            done_r;
  logic            sgn_r;
  logic [AW-1:0]   a_r;
  logic [AW-1:0]   m_r;
  logic [AW-1:0]   a_sum_s;
  logic [AW-1:0]   a_nxt_s;
  logic [QW-1:0]   q_r;
  logic [QW-1:0]   q_nxt_s;
  logic            q_m1_r;
  logic            q_m1_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [PW-1:0]   prod_s;
  logic [PW-1:0]   result_r;

  // Next-state decode; IDLE and FIN accept a new request identically
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE, FIN: begin
        if (bus.start) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_STEP) begin
          state_nxt_s = FIN;
          last_s      = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // One Booth step: add/subtract M, then arithmetic shift of {A,Q,Q_-1}
  always_comb begin
    a_sum_s = a_r;
    case ({q_r[0], q_m1_r})
      2'b10:   a_sum_s = a_r - m_r;
      2'b01:   a_sum_s = a_r + m_r;
      default: a_sum_s = a_r;
    endcase
    a_nxt_s    = {a_sum_s[AW-1], a_sum_s[AW-1:1]};
    q_nxt_s    = {a_sum_s[0], q_r[QW-1:1]};
    q_m1_nxt_s = q_r[0];
    prod_s     = {a_nxt_s[WIDTH-2:0], q_nxt_s};
  end

  // State and handshake flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == FIN);
    end
  end

  // Operand capture, iteration and product update
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r      <= {AW{1'b0}};
      m_r      <= {AW{1'b0}};
      q_r      <= {QW{1'b0}};
      q_m1_r   <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      sgn_r    <= 1'b0;
      result_r <= {PW{1'b0}};
    end else if (accept_s) begin
      // Two extra M bits keep A - M exact for zero-extended unsigned operands
      a_r    <= {AW{1'b0}};
      m_r    <= bus.signed_mode ? {{2{bus.data1[WIDTH-1]}}, bus.data1} : {2'b00, bus.data1};
      q_r    <= bus.signed_mode ? {bus.data2[WIDTH-1], bus.data2} : {1'b0, bus.data2};
      q_m1_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      sgn_r  <= bus.signed_mode;
    end else if (state_r == RUN) begin
      a_r    <= a_nxt_s;
      q_r    <= q_nxt_s;
      q_m1_r <= q_m1_nxt_s;
      cnt_r  <= cnt_r + CNT_ONE;
      if (last_s) begin
        result_r <= prod_s;
      end
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.result  = result_r;
  assign bus.mul_out = result_r[WIDTH-1:0];

`ifdef SEQ_MUL_OVERFLOW_FLAG_EN
  logic overflow_r;

  function automatic logic ovf_check(input logic [PW-1:0] p, input logic sgn);
    logic [WIDTH:0] hi_s;
    hi_s = p[PW-1:WIDTH-1];
    if (sgn) begin
      return (|hi_s) && !(&hi_s);
    end else begin
      return |p[PW-1:WIDTH];
    end
  endfunction

  // Overflow flag follows every product update
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if ((state_r == RUN) && last_s) begin
      overflow_r <= ovf_check(prod_s, sgn_r);
    end
  end

  assign bus.overflow = overflow_r;
`endif

endmodule

// File: tb/tb_seq_mul_param.sv
// Directed-vector bench for seq_mul_param at WIDTH=8 with hand-computed products.
// Overflow checks are active when SEQ_MUL_OVERFLOW_FLAG_EN is defined.
module tb_seq_mul_param;
  localparam int W = 8;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [15:0] last_res;

  seq_mul_param_if #(.WIDTH(W)) bus ();

  seq_mul_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch at edge k, check BUSY over k..k+W, DONE and product after k+W+1.
  // poke > 0 pulses START with other operands at that RUN cycle.
  task automatic run_op(input string tag, input logic [7:0] d1, input logic [7:0] d2,
                        input logic sm, input logic [15:0] exp_res, input logic exp_ov,
                        input int poke);
    bus.data1       = d1;
    bus.data2       = d2;
    bus.signed_mode = sm;
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
    bus.data1       = 8'hA5;
    bus.data2       = 8'h5A;
    bus.signed_mode = ~sm;
    check_eq({tag, "_busy_k"}, 64'(bus.busy), 64'(1'b1));
    check_eq({tag, "_done_k"}, 64'(bus.done), 64'(1'b0));
    for (int i = 1; i <= W; i++) begin
      if (i == poke) begin
        bus.start       = 1'b1;
        bus.data1       = 8'h11;
        bus.data2       = 8'h22;
      end else begin
        bus.start       = 1'b0;
      end
      tick();
      check_eq({tag, "_busy_run"}, 64'(bus.busy), 64'(1'b1));
      check_eq({tag, "_done_run"}, 64'(bus.done), 64'(1'b0));
    end
    check_eq({tag, "_hold"}, 64'(bus.result), 64'(last_res));
    bus.start = 1'b0;
    tick();
    check_eq({tag, "_done"}, 64'(bus.done), 64'(1'b1));
    check_eq({tag, "_busy_end"}, 64'(bus.busy), 64'(1'b0));
    check_eq({tag, "_result"}, 64'(bus.result), 64'(exp_res));
    check_eq({tag, "_mul_out"}, 64'(bus.mul_out), 64'(exp_res[7:0]));
`ifdef SEQ_MUL_OVERFLOW_FLAG_EN
    check_eq({tag, "_ovf"}, 64'(bus.overflow), 64'(exp_ov));
`else
    if (exp_ov !== exp_ov) begin
      bad++;
    end
`endif
    last_res = exp_res;
  endtask

  // Idle cycle after FIN: DONE must drop and result must hold
  task automatic idle_check(input string tag);
    tick();
    check_eq({tag, "_done_drop"}, 64'(bus.done), 64'(1'b0));
    check_eq({tag, "_idle_busy"}, 64'(bus.busy), 64'(1'b0));
    check_eq({tag, "_idle_hold"}, 64'(bus.result), 64'(last_res));
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    last_res        = 16'h0000;
    reset           = 1'b1;
    bus.start       = 1'b1;
    bus.signed_mode = 1'b0;
    bus.data1       = 8'h00;
    bus.data2       = 8'h00;
    tick();
    tick();
    check_eq("rst_busy", 64'(bus.busy), 64'(1'b0));
    check_eq("rst_done", 64'(bus.done), 64'(1'b0));
    check_eq("rst_result", 64'(bus.result), 64'(16'h0000));
    check_eq("rst_mul_out", 64'(bus.mul_out), 64'(8'h00));
`ifdef SEQ_MUL_OVERFLOW_FLAG_EN
    check_eq("rst_ovf", 64'(bus.overflow), 64'(1'b0));
`endif
    bus.start = 1'b0;
    reset     = 1'b0;
    tick();

    run_op("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0, 0);
    idle_check("s_m3x5");
    run_op("u_253x5", 8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b1, 0);
    idle_check("u_253x5");
    run_op("s_minxmin", 8'h80, 8'h80, 1'b1, 16'h4000, 1'b1, 0);
    idle_check("s_minxmin");
    run_op("s_zero", 8'h00, 8'h7F, 1'b1, 16'h0000, 1'b0, 0);
    idle_check("s_zero");
    run_op("s_maxxmin", 8'h7F, 8'h80, 1'b1, 16'hC080, 1'b1, 0);
    idle_check("s_maxxmin");
    run_op("u_small", 8'h12, 8'h34, 1'b0, 16'h03A8, 1'b1, 0);
    idle_check("u_small");

    // Back-to-back: the second launch is sampled in the FIN cycle
    run_op("u_maxxmax", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1, 0);
    run_op("b2b_s_m1xm1", 8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0, 0);
    idle_check("b2b");

    run_op("mid_start", 8'h07, 8'h06, 1'b1, 16'h002A, 1'b0, 3);
    idle_check("mid_start");

    // Reset at the fourth RUN cycle with START held high
    bus.data1       = 8'h19;
    bus.data2       = 8'h0B;
    bus.signed_mode = 1'b0;
    bus.start       = 1'b1;
    tick();
    check_eq("abort_busy_k", 64'(bus.busy), 64'(1'b1));
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_eq("abort_busy", 64'(bus.busy), 64'(1'b0));
    check_eq("abort_done", 64'(bus.done), 64'(1'b0));
    check_eq("abort_result", 64'(bus.result), 64'(16'h0000));
    reset    = 1'b0;
    last_res = 16'h0000;
    run_op("relaunch", 8'h19, 8'h0B, 1'b0, 16'h0113, 1'b1, 0);
    idle_check("relaunch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
